relu_seq_ctrl: RTL and testbench

Sequencer that streams a vector of LEN words from a read port through one Relu unit and writes the results to a write port.
- Drives the Relu unit's running/in0 and captures its out0.
- Generates read and write addresses and tracks the fixed datapath latency with a valid/address pipeline.
- Sits between the accelerator's config registers and a memory-attached Relu datapath unit.

---
 rtl/relu_seq_ctrl_if.sv | 38 +++
 rtl/relu_seq_ctrl.sv | 105 ++++++++++
 tb/tb_relu_seq_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/relu_seq_ctrl_if.sv
// Purpose : bundles the config, read-port, Relu-unit and write-port signals of relu_seq_ctrl.
// Latency : n/a (wiring only).
// Backpressure: none; the read port, unit and write port are fixed-latency and always accept.
// Ports   : master = environment (config regs, memory, Relu unit); slave = the sequencer.
interface relu_seq_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16,
   parameter int LEN_W  = 16
);
   logic              start_i;
   logic              abort_i;
   logic [LEN_W-1:0]  len_i;
   logic [ADDR_W-1:0] rd_base_i;
   logic [ADDR_W-1:0] wr_base_i;
   logic              busy_o;
   logic              done_o;
   logic              rd_en_o;
   logic [ADDR_W-1:0] rd_addr_o;
   logic [DATA_W-1:0] rd_data_i;
   logic              unit_running_o;
   logic [DATA_W-1:0] unit_in0_o;
   logic [DATA_W-1:0] unit_out0_i;
   logic              wr_en_o;
   logic [ADDR_W-1:0] wr_addr_o;
   logic [DATA_W-1:0] wr_data_o;

   modport master (
      output start_i, abort_i, len_i, rd_base_i, wr_base_i, rd_data_i, unit_out0_i,
      input  busy_o, done_o, rd_en_o, rd_addr_o, unit_running_o, unit_in0_o,
             wr_en_o, wr_addr_o, wr_data_o
   );

   modport slave (
      input  start_i, abort_i, len_i, rd_base_i, wr_base_i, rd_data_i, unit_out0_i,
      output busy_o, done_o, rd_en_o, rd_addr_o, unit_running_o, unit_in0_o,
             wr_en_o, wr_addr_o, wr_data_o
   );
endinterface

// File: rtl/relu_seq_ctrl.sv
// Purpose : streams len words from a read port through a Relu unit into a write port.
// Latency : write for element k lands RD_LAT+UNIT_LAT cycles after its read; done one cycle after last write.
// Backpressure: none; one read issued per cycle in ISSUE, abort_i flushes everything in flight.
// Ports   : clk, rst (sync, active-high); bus = slave side of relu_seq_ctrl_if
//           (config start/abort/len/bases, read strobe/addr/data, unit running/in0/out0, write strobe/addr/data).
module relu_seq_ctrl #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 16,
   parameter int LEN_W    = 16,
   parameter int RD_LAT   = 1,
   parameter int UNIT_LAT = 1
) (
   input  logic           clk,
   input  logic           rst,
   relu_seq_ctrl_if.slave bus
);
   localparam int L = RD_LAT + UNIT_LAT;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t            state, state_nxt;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  rd_cnt;
   logic [LEN_W-1:0]  wr_cnt;
   logic [ADDR_W-1:0] rd_base;
   logic [ADDR_W-1:0] wr_base;
   logic [L-1:0]      vpipe;
   logic [L-1:0]      vpipe_nxt;
   logic              rd_en;
   logic              wr_en;
   logic              accept;

   assign rd_en  = (state == ISSUE);
   assign wr_en  = vpipe[L-1];
   assign accept = (state == IDLE) && bus.start_i && !bus.abort_i && (bus.len_i != '0);

   // Bit i set means a read issued i+1 cycles ago is still in flight; the top tap
   // lines up with the unit output for that element.
   assign vpipe_nxt = (vpipe << 1) | L'(rd_en);

   always_comb begin
      state_nxt = state;
      if (bus.abort_i) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start_i) state_nxt = (bus.len_i != '0) ? ISSUE : DONE;
            end
            ISSUE: begin
               if (rd_cnt == len_q - LEN_W'(1)) state_nxt = DRAIN;
            end
            DRAIN: begin
               // Leave as the last in-flight element is written, so done follows it directly.
               if (vpipe_nxt == '0) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         len_q   <= '0;
         rd_base <= '0;
         wr_base <= '0;
         rd_cnt  <= '0;
         wr_cnt  <= '0;
         vpipe   <= '0;
      end else begin
         state <= state_nxt;
         if (bus.abort_i) begin
            // Config is kept on abort; only in-flight work is discarded.
            rd_cnt <= '0;
            wr_cnt <= '0;
            vpipe  <= '0;
         end else begin
            vpipe <= vpipe_nxt;
            if (accept) begin
               len_q   <= bus.len_i;
               rd_base <= bus.rd_base_i;
               wr_base <= bus.wr_base_i;
               rd_cnt  <= '0;
               wr_cnt  <= '0;
            end else begin
               if (rd_en) rd_cnt <= rd_cnt + LEN_W'(1);
               if (wr_en) wr_cnt <= wr_cnt + LEN_W'(1);
            end
         end
      end
   end

   // Addresses wrap modulo 2^ADDR_W.
   assign bus.rd_addr_o      = rd_base + ADDR_W'(rd_cnt);
   assign bus.wr_addr_o      = wr_base + ADDR_W'(wr_cnt);
   assign bus.rd_en_o        = rd_en;
   assign bus.wr_en_o        = wr_en;
   assign bus.busy_o         = (state == ISSUE) || (state == DRAIN);
   assign bus.done_o         = (state == DONE);
   assign bus.unit_running_o = (state == ISSUE) || (state == DRAIN);
   assign bus.unit_in0_o     = bus.rd_data_i;
   assign bus.wr_data_o      = bus.unit_out0_i;
endmodule

// File: tb/tb_relu_seq_ctrl.sv
module tb_relu_seq_ctrl;
   logic clk;
   logic rst;
   int   sel;
   logic start;
   logic abort;
   logic [15:0] len_d;
   logic [15:0] rb_d;
   logic [15:0] wb_d;

   logic [31:0] mem [0:65535];

   relu_seq_ctrl_if #(.DATA_W(32), .ADDR_W(16), .LEN_W(16)) ifa ();
   relu_seq_ctrl_if #(.DATA_W(32), .ADDR_W(16), .LEN_W(16)) ifb ();

   relu_seq_ctrl #(.DATA_W(32), .ADDR_W(16), .LEN_W(16), .RD_LAT(1), .UNIT_LAT(1))
      dut_a (.clk(clk), .rst(rst), .bus(ifa));
   relu_seq_ctrl #(.DATA_W(32), .ADDR_W(16), .LEN_W(16), .RD_LAT(2), .UNIT_LAT(3))
      dut_b (.clk(clk), .rst(rst), .bus(ifb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] relu(input logic [31:0] x);
      return x[31] ? 32'h0 : x;
   endfunction

   assign ifa.start_i   = start && (sel == 0);
   assign ifa.abort_i   = abort && (sel == 0);
   assign ifa.len_i     = len_d;
   assign ifa.rd_base_i = rb_d;
   assign ifa.wr_base_i = wb_d;
   assign ifb.start_i   = start && (sel == 1);
   assign ifb.abort_i   = abort && (sel == 1);
   assign ifb.len_i     = len_d;
   assign ifb.rd_base_i = rb_d;
   assign ifb.wr_base_i = wb_d;

   // Memory + Relu unit models: A is 1+1 cycles, B is 2+3 cycles.
   logic [31:0] rd_a, up_a;
   logic [31:0] rdp_b [2];
   logic [31:0] up_b  [3];
   always @(posedge clk) begin
      rd_a <= mem[ifa.rd_addr_o];
      if (ifa.unit_running_o) up_a <= relu(ifa.unit_in0_o);
      rdp_b[0] <= mem[ifb.rd_addr_o];
      rdp_b[1] <= rdp_b[0];
      if (ifb.unit_running_o) begin
         up_b[0] <= relu(ifb.unit_in0_o);
         up_b[1] <= up_b[0];
         up_b[2] <= up_b[1];
      end
   end
   assign ifa.rd_data_i   = rd_a;
   assign ifa.unit_out0_i = up_a;
   assign ifb.rd_data_i   = rdp_b[1];
   assign ifb.unit_out0_i = up_b[2];

   logic        s_rd_en, s_wr_en, s_done, s_busy, s_run;
   logic [15:0] s_rd_addr, s_wr_addr;
   logic [31:0] s_wr_data;
   always_comb begin
      s_rd_en = ifa.rd_en_o; s_wr_en = ifa.wr_en_o; s_done = ifa.done_o;
      s_busy = ifa.busy_o; s_run = ifa.unit_running_o;
      s_rd_addr = ifa.rd_addr_o; s_wr_addr = ifa.wr_addr_o; s_wr_data = ifa.wr_data_o;
      if (sel == 1) begin
         s_rd_en = ifb.rd_en_o; s_wr_en = ifb.wr_en_o; s_done = ifb.done_o;
         s_busy = ifb.busy_o; s_run = ifb.unit_running_o;
         s_rd_addr = ifb.rd_addr_o; s_wr_addr = ifb.wr_addr_o; s_wr_data = ifb.wr_data_o;
      end
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   // Per-run observations.
   int n_rd, n_wr, first_rd, first_wr, done_cyc, n_done, busy_cnt, last_act, run_bad;
   logic [15:0] rd_addrs [$];
   logic [15:0] wr_addrs [$];
   logic [31:0] wr_datas [$];

   task automatic run(input int s, input int len, input logic [15:0] rb, input logic [15:0] wb,
                      input int start2_at, input int len2, input int abort_at, input int ncyc);
      n_rd = 0; n_wr = 0; first_rd = -1; first_wr = -1; done_cyc = -1; n_done = 0;
      busy_cnt = 0; last_act = -1; run_bad = 0;
      rd_addrs.delete(); wr_addrs.delete(); wr_datas.delete();
      @(negedge clk);
      sel = s; len_d = 16'(len); rb_d = rb; wb_d = wb; start = 1'b1; abort = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         if (s_rd_en) begin
            n_rd++; if (first_rd < 0) first_rd = c; rd_addrs.push_back(s_rd_addr);
         end
         if (s_wr_en) begin
            n_wr++; if (first_wr < 0) first_wr = c;
            wr_addrs.push_back(s_wr_addr); wr_datas.push_back(s_wr_data);
         end
         if (s_done) begin
            n_done++; if (done_cyc < 0) done_cyc = c;
         end
         if (s_busy) busy_cnt++;
         if (s_rd_en || s_wr_en || s_busy) last_act = c;
         if (s_run != s_busy) run_bad++;
         start = (c == start2_at);
         if (c == start2_at) len_d = 16'(len2);
         abort = (c == abort_at);
      end
      start = 1'b0; abort = 1'b0;
   endtask

   typedef struct {
      int sel; int len; logic [15:0] rb; logic [15:0] wb;
      int start2_at; int len2; int abort_at;
      int e_nrd; int e_nwr; int e_first_wr; int e_done; int e_ndone; int e_busy; int e_last;
   } vec_t;

   vec_t tv [8];
   logic [31:0] hand0 [5];

   task automatic chk_idle_outputs(input string tag, input int which);
      if (which == 0) begin
         chk({tag, "_a_busy"}, ifa.busy_o, 0);    chk({tag, "_a_done"}, ifa.done_o, 0);
         chk({tag, "_a_rd_en"}, ifa.rd_en_o, 0);  chk({tag, "_a_wr_en"}, ifa.wr_en_o, 0);
         chk({tag, "_a_rd_addr"}, ifa.rd_addr_o, 0); chk({tag, "_a_wr_addr"}, ifa.wr_addr_o, 0);
         chk({tag, "_a_running"}, ifa.unit_running_o, 0);
      end else begin
         chk({tag, "_b_busy"}, ifb.busy_o, 0);    chk({tag, "_b_done"}, ifb.done_o, 0);
         chk({tag, "_b_rd_en"}, ifb.rd_en_o, 0);  chk({tag, "_b_wr_en"}, ifb.wr_en_o, 0);
         chk({tag, "_b_rd_addr"}, ifb.rd_addr_o, 0); chk({tag, "_b_wr_addr"}, ifb.wr_addr_o, 0);
         chk({tag, "_b_running"}, ifb.unit_running_o, 0);
      end
   endtask

   initial begin
      logic [15:0] a;
      for (int i = 0; i < 65536; i++) begin
         a = 16'(i);
         mem[i] = {a, ~a};
      end
      mem[16'h10] = 32'd5;
      mem[16'h11] = 32'hFFFF_FFFD;
      mem[16'h12] = 32'h0;
      mem[16'h13] = 32'h7FFF_FFFF;
      mem[16'h14] = 32'h8000_0000;
      hand0[0] = 32'd5; hand0[1] = 32'h0; hand0[2] = 32'h0; hand0[3] = 32'h7FFF_FFFF; hand0[4] = 32'h0;

      //           sel len rb        wb        s2 len2 ab   nrd nwr fwr done ndone busy last
      tv[0] = '{0, 5, 16'h0010, 16'h0040, -1, 0, -1,  5, 5, 3,  8, 1, 7, 7};
      tv[1] = '{0, 0, 16'h0010, 16'h0040, -1, 0, -1,  0, 0, -1, 1, 1, 0, -1};
      tv[2] = '{0, 3, 16'hFFFE, 16'hFFFF, -1, 0, -1,  3, 3, 3,  6, 1, 5, 5};
      tv[3] = '{0, 4, 16'h0030, 16'h0050,  2, 9, -1,  4, 4, 3,  7, 1, 6, 6};
      tv[4] = '{0, 2, 16'h0020, 16'h0060, -1, 0, -1,  2, 2, 3,  5, 1, 4, 4};
      tv[5] = '{0, 8, 16'h0100, 16'h0200, -1, 0,  3,  3, 1, 3, -1, 0, 3, 3};
      tv[6] = '{0, 2, 16'h0008, 16'h0070, -1, 0, -1,  2, 2, 3,  5, 1, 4, 4};
      tv[7] = '{1, 4, 16'h0010, 16'h0090, -1, 0, -1,  4, 4, 6, 10, 1, 9, 9};

      sel = 0; start = 1'b0; abort = 1'b0; len_d = '0; rb_d = '0; wb_d = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_idle_outputs("reset", 0);
      chk_idle_outputs("reset", 1);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         string t;
         t = $sformatf("v%0d", i);
         run(tv[i].sel, tv[i].len, tv[i].rb, tv[i].wb, tv[i].start2_at, tv[i].len2, tv[i].abort_at, 20);
         chk({t, "_n_rd"}, n_rd, tv[i].e_nrd);
         chk({t, "_n_wr"}, n_wr, tv[i].e_nwr);
         chk({t, "_first_rd"}, first_rd, (tv[i].e_nrd > 0) ? 1 : -1);
         chk({t, "_first_wr"}, first_wr, tv[i].e_first_wr);
         chk({t, "_done_cyc"}, done_cyc, tv[i].e_done);
         chk({t, "_n_done"}, n_done, tv[i].e_ndone);
         chk({t, "_busy_cnt"}, busy_cnt, tv[i].e_busy);
         chk({t, "_last_act"}, last_act, tv[i].e_last);
         chk({t, "_running_eq_busy"}, run_bad, 0);
         for (int k = 0; k < rd_addrs.size(); k++)
            chk($sformatf("%s_rd_addr%0d", t, k), rd_addrs[k], 16'(tv[i].rb + 16'(k)));
         for (int k = 0; k < wr_addrs.size(); k++) begin
            chk($sformatf("%s_wr_addr%0d", t, k), wr_addrs[k], 16'(tv[i].wb + 16'(k)));
            chk($sformatf("%s_wr_data%0d", t, k), wr_datas[k], relu(mem[16'(tv[i].rb + 16'(k))]));
         end
         if (i == 0) begin
            for (int k = 0; k < 5 && k < wr_datas.size(); k++)
               chk($sformatf("hand_data%0d", k), wr_datas[k], hand0[k]);
         end
         if (i == 2 && rd_addrs.size() == 3 && wr_addrs.size() == 3) begin
            chk("wrap_rd0", rd_addrs[0], 16'hFFFE);
            chk("wrap_rd1", rd_addrs[1], 16'hFFFF);
            chk("wrap_rd2", rd_addrs[2], 16'h0000);
            chk("wrap_wr0", wr_addrs[0], 16'hFFFF);
            chk("wrap_wr1", wr_addrs[1], 16'h0000);
            chk("wrap_wr2", wr_addrs[2], 16'h0001);
         end
      end

      // Synchronous reset in the middle of a long-latency run.
      @(negedge clk);
      sel = 1; len_d = 16'd4; rb_d = 16'h0010; wb_d = 16'h0090; start = 1'b1;
      @(negedge clk);   // cycle 1
      start = 1'b0;
      chk("rst_mid_busy_before", ifb.busy_o, 1);
      @(negedge clk);   // cycle 2
      @(negedge clk);   // cycle 3
      rst = 1'b1;
      @(negedge clk);   // cycle 4
      chk_idle_outputs("rst_mid", 1);
      rst = 1'b0;
      run(1, 4, 16'h0010, 16'h0090, -1, 0, -1, 20);
      chk("after_rst_n_wr", n_wr, 4);
      chk("after_rst_done_cyc", done_cyc, 10);
      chk("after_rst_wr_addr0", (wr_addrs.size() > 0) ? wr_addrs[0] : 16'hDEAD, 16'h0090);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
